btn_conditioner: RTL and testbench

- Input conditioner that sits directly upstream of the lab6 registers.
- Takes a raw, asynchronous push-button or switch level and synchronises it into clk, then debounces it.
- Delivers a clean level plus one-cycle rise, fall and long-press pulses and a press counter.
- Its outputs drive the d inputs of downstream registers and share the same clk and rstn.

---
 rtl/btn_conditioner.sv | 130 +++++++++++++
 tb/tb_btn_conditioner.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// Button/switch conditioner: synchronises a raw asynchronous level into clk,
// debounces it, and produces a clean level, edge/long-press pulses and a press count.
module btn_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DB_W            = 16,
  parameter int LONG_CYCLES     = 64,
  parameter int LONG_W          = 24,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             btn_in,
  output logic             level_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             long_pulse,
  output logic [CNT_W-1:0] press_count
);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_e;

  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYCLES);
  localparam logic [LONG_W-1:0] LONG_PRE = LONG_W'(LONG_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_sync;
  state_e                 state_q, state_d;
  logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
  logic [LONG_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d, fall_q, fall_d, long_q, long_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  // btn_in enters stage 0; only the last stage is considered metastability-safe
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
  end
  assign btn_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      level_q    <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      long_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      level_q    <= level_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      long_q     <= long_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    hold_cnt_d = hold_cnt_q;
    level_d    = level_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    long_d     = 1'b0;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (btn_sync) begin
          state_d  = PRESS_WAIT;
          db_cnt_d = DB_W'(1);
        end
      end
      PRESS_WAIT: begin
        if (!btn_sync) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d    = PRESSED;
          db_cnt_d   = '0;
          level_d    = 1'b1;
          rise_d     = 1'b1;
          cnt_d      = cnt_q + CNT_W'(1);
          hold_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      PRESSED: begin
        if (!btn_sync) begin
          state_d  = RELEASE_WAIT;
          db_cnt_d = DB_W'(1);
        end else if (hold_cnt_q < LONG_MAX) begin
          // saturating at LONG_MAX keeps long_pulse to one per press
          hold_cnt_d = hold_cnt_q + LONG_W'(1);
          long_d     = (hold_cnt_q == LONG_PRE);
        end
      end
      RELEASE_WAIT: begin
        // a rejected release glitch resumes the hold count where it was
        if (btn_sync) begin
          state_d  = PRESSED;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = IDLE;
          db_cnt_d = '0;
          level_d  = 1'b0;
          fall_d   = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign level_out   = level_q;
  assign rise_pulse  = rise_q;
  assign fall_pulse  = fall_q;
  assign long_pulse  = long_q;
  assign press_count = cnt_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios plus random bouncing input,
// compared every cycle against a run-length reference model.
module tb_btn_conditioner;
  localparam int SS = 2, DB = 16, DB_W = 16, LONG = 64, LONG_W = 24, CNT_W = 8;

  logic             clk, rstn, btn_in;
  logic             level_out, rise_pulse, fall_pulse, long_pulse;
  logic [CNT_W-1:0] press_count;

  int n_chk = 0, n_fail = 0;

  btn_conditioner #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB), .DB_W(DB_W),
                    .LONG_CYCLES(LONG), .LONG_W(LONG_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rstn(rstn), .btn_in(btn_in), .level_out(level_out),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .long_pulse(long_pulse),
    .press_count(press_count));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: btn_sync is btn_in delayed SS edges; a change is accepted
  // once the new value has been seen DB times in a row.
  logic             m_hist [SS];
  int               m_run, m_hold;
  logic             m_level, m_rise, m_fall, m_long;
  logic [CNT_W-1:0] m_cnt;

  function automatic void model_reset();
    for (int i = 0; i < SS; i++) m_hist[i] = 1'b0;
    m_run = 0; m_hold = 0; m_level = 1'b0; m_cnt = '0;
    m_rise = 1'b0; m_fall = 1'b0; m_long = 1'b0;
  endfunction

  function automatic void model_step(input logic b);
    logic s;
    s = m_hist[SS-1];
    for (int i = SS-1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = b;
    m_rise = 1'b0; m_fall = 1'b0; m_long = 1'b0;
    if (s != m_level) begin
      m_run++;
      if (m_run == DB) begin
        m_level = s;
        m_run   = 0;
        if (s) begin m_rise = 1'b1; m_cnt++; m_hold = 0; end
        else   m_fall = 1'b1;
      end
    end else begin
      // hold time only advances while pressed and not inside a release glitch
      if (m_level && m_run == 0 && m_hold < LONG) begin
        m_hold++;
        if (m_hold == LONG) m_long = 1'b1;
      end
      m_run = 0;
    end
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) model_reset();
    else       model_step(btn_in);
  end

  always @(negedge clk) begin
    if (rstn) begin
      chk("level", level_out, m_level);
      chk("rise", rise_pulse, m_rise);
      chk("fall", fall_pulse, m_fall);
      chk("long", long_pulse, m_long);
      chk("count", press_count, m_cnt);
    end
  end

  task automatic drive(input logic v, input int n);
    btn_in = v;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_lvl"}, level_out, 0);
    chk({tag, "_pulses"}, {rise_pulse, fall_pulse, long_pulse}, 0);
    chk({tag, "_cnt"}, press_count, 0);
  endtask

  int nr, nl, nf;

  initial begin
    rstn = 1'b0; btn_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk_all_zero("rst_hold");
    // release between edges with btn high: treated as a new press
    @(negedge clk); rstn = 1'b1;
    repeat (17) @(posedge clk);
    #1 chk("rst_e17_lvl", level_out, 0);
    @(posedge clk); #1;
    chk("rst_e18_lvl", level_out, 1);
    chk("rst_e18_rise", rise_pulse, 1);
    chk("rst_e18_cnt", press_count, 1);
    drive(1'b0, 40);

    // async reset while debouncing a press (db count 7)
    drive(1'b1, 9);
    #2 rstn = 1'b0;
    #1 chk_all_zero("rst_presswait");
    btn_in = 1'b0;
    @(negedge clk); rstn = 1'b1;
    drive(1'b0, 10);

    // clean press held 200 cycles
    btn_in = 1'b1; nr = 0; nl = 0;
    for (int e = 1; e <= 200; e++) begin
      @(posedge clk); #1;
      nr += int'(rise_pulse); nl += int'(long_pulse);
      if (e == 18) chk("clean_rise_e18", rise_pulse, 1);
      if (e == 82) chk("clean_long_e82", long_pulse, 1);
    end
    chk("clean_rise_n", nr, 1);
    chk("clean_long_n", nl, 1);
    // async reset while pressed, well before the next clock edge
    #2 rstn = 1'b0;
    #1 chk_all_zero("rst_pressed");
    btn_in = 1'b0;
    @(negedge clk); rstn = 1'b1;
    drive(1'b0, 10);

    // bounce shorter than the debounce window
    drive(1'b1, 5); drive(1'b0, 3); drive(1'b1, 10); drive(1'b0, 30);
    chk("bounce_lvl", level_out, 0);
    chk("bounce_cnt", press_count, 0);

    // release glitch, then real release
    drive(1'b1, 25);
    drive(1'b0, 8); drive(1'b1, 20);
    chk("glitch_lvl", level_out, 1);
    btn_in = 1'b0; nf = 0;
    for (int e = 0; e < 30; e++) begin @(posedge clk); #1; nf += int'(fall_pulse); end
    chk("release_fall_n", nf, 1);
    chk("release_lvl", level_out, 0);

    // random bouncy segments
    for (int k = 0; k < 80; k++) drive(1'($urandom_range(0, 1)), $urandom_range(1, 40));
    drive(1'b0, 30);

    // press counter wrap
    @(negedge clk); rstn = 1'b0;
    @(negedge clk); rstn = 1'b1;
    for (int p = 1; p <= 256; p++) begin
      drive(1'b1, 20);
      if (p == 255) chk("wrap_255", press_count, 255);
      if (p == 256) chk("wrap_256", press_count, 0);
      drive(1'b0, 20);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
